// File: rtl/memoria_banked_rw.sv
// memoria_banked_rw: byte-interleaved banked data memory with single-cycle unaligned access,
// load extension, range/size error reporting and an optional post-reset clear.
module memoria_banked_rw #(
  parameter int DATA_W         = 32,
  parameter int MEM_BYTES      = 65536,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_init_done
);
  localparam int NB   = DATA_W / 8;
  localparam int OW   = $clog2(NB);
  localparam int AW   = $clog2(MEM_BYTES);
  localparam int ROWS = MEM_BYTES / NB;
  localparam int RW   = AW - OW;
  typedef enum logic {INIT, RUN} state_t;
  state_t r_state, w_state_next;
  logic [RW-1:0] r_cnt;
  always_comb begin
    w_state_next = r_state;
    if (r_state == INIT && (!CLEAR_ON_RESET || r_cnt == RW'(ROWS - 1))) w_state_next = RUN;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (r_state == INIT) ? r_cnt + 1'b1 : '0;
    end
  end
  assign o_req_ready = r_state == RUN;
  assign o_init_done = r_state == RUN;
  logic          w_fire, w_err, w_clr;
  logic [3:0]    w_n;
  logic [OW-1:0] w_off;
  logic [RW-1:0] w_row;
  assign w_n    = 4'd1 << i_req_size;
  assign w_off  = i_req_addr[OW-1:0];
  assign w_row  = i_req_addr[AW-1:OW];
  assign w_fire = i_req_valid && o_req_ready && !i_rst;
  assign w_clr  = CLEAR_ON_RESET && r_state == INIT && !i_rst;
  // the last touched byte must not carry past the top of memory
  assign w_err  = (i_req_size == 2'd3 && DATA_W == 32) || ((i_req_addr >> AW) != 32'd0)
               || ((({1'b0, i_req_addr[AW-1:0]} + (AW+1)'(w_n) - (AW+1)'(1)) >> AW) != '0);
  logic [DATA_W-1:0] w_rd;
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [7:0]    r_mem [ROWS];
    logic [7:0]    r_q;
    logic [OW-1:0] w_lane;
    logic [RW-1:0] w_brow;
    logic          w_wen;
    assign w_lane = OW'(b) - w_off;
    assign w_brow = (OW'(b) < w_off) ? w_row + 1'b1 : w_row;
    assign w_wen  = w_fire && i_req_we && !w_err && (4'(w_lane) < w_n);
    always_ff @(posedge i_clk) begin
      if (w_clr) r_mem[r_cnt] <= '0;
      else if (w_wen) r_mem[w_brow] <= i_req_wdata[{w_lane, 3'b000} +: 8];
      r_q <= r_mem[w_brow];
    end
    assign w_rd[8*b +: 8] = r_q;
  end
  logic          r_v1, r_we1, r_err1, r_uns1;
  logic [1:0]    r_size1;
  logic [OW-1:0] r_off1;
  always_ff @(posedge i_clk) begin
    r_v1    <= w_fire;
    r_we1   <= i_req_we;
    r_err1  <= w_err;
    r_uns1  <= i_req_unsigned;
    r_size1 <= i_req_size;
    r_off1  <= w_off;
  end
  logic [DATA_W-1:0] w_rot, w_ext;
  logic [3:0]        w_n1;
  logic              w_sign;
  assign w_n1  = 4'd1 << r_size1;
  assign w_rot = DATA_W'({w_rd, w_rd} >> {r_off1, 3'b000});
  always_comb begin
    w_sign = 1'b0;
    w_ext  = '0;
    for (int k = 0; k < NB; k++) if (k + 1 == int'(w_n1)) w_sign = w_rot[8*k+7];
    for (int k = 0; k < NB; k++) w_ext[8*k +: 8] = (k < int'(w_n1)) ? w_rot[8*k +: 8] : {8{w_sign && !r_uns1}};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      o_rsp_valid <= r_v1;
      o_rsp_err   <= r_v1 && r_err1;
      o_rsp_rdata <= (r_v1 && !r_we1 && !r_err1) ? w_ext : '0;
    end
  end
endmodule

// File: tb/tb_memoria_banked_rw.sv
// tb_memoria_banked_rw: randomized checks of the banked memory against a byte-array model,
// using a 32-bit and a 64-bit instance of 1 KiB each.
module tb_memoria_banked_rw;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        v32 = 0, we32 = 0, u32 = 0, rdy32, rv32, er32, id32;
  logic [31:0] a32 = 0, wd32 = 0, rd32;
  logic [1:0]  s32 = 0;
  logic        v64 = 0, we64 = 0, u64 = 0, rdy64, rv64, er64, id64;
  logic [31:0] a64 = 0;
  logic [63:0] wd64 = 0, rd64;
  logic [1:0]  s64 = 0;
  memoria_banked_rw #(.DATA_W(32), .MEM_BYTES(1024), .CLEAR_ON_RESET(1'b1)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v32), .o_req_ready(rdy32), .i_req_we(we32),
    .i_req_addr(a32), .i_req_size(s32), .i_req_unsigned(u32), .i_req_wdata(wd32),
    .o_rsp_valid(rv32), .o_rsp_rdata(rd32), .o_rsp_err(er32), .o_init_done(id32));
  memoria_banked_rw #(.DATA_W(64), .MEM_BYTES(1024), .CLEAR_ON_RESET(1'b1)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(v64), .o_req_ready(rdy64), .i_req_we(we64),
    .i_req_addr(a64), .i_req_size(s64), .i_req_unsigned(u64), .i_req_wdata(wd64),
    .o_rsp_valid(rv64), .o_rsp_rdata(rd64), .o_rsp_err(er64), .o_init_done(id64));
  logic [7:0] m32 [1024];
  logic [7:0] m64 [1024];
  int vecs = 0, errs = 0;
  function automatic void model_clear();
    for (int i = 0; i < 1024; i++) begin
      m32[i] = 8'h00;
      m64[i] = 8'h00;
    end
  endfunction
  function automatic bit is_err(int dw, logic [31:0] a, logic [1:0] s);
    return (s == 2'd3 && dw == 32) || ({32'h0, a} + (64'd1 << s) - 64'd1 >= 64'd1024);
  endfunction
  function automatic logic [63:0] model_load(bit w64, logic [31:0] a, logic [1:0] s, bit u, bit we, bit er);
    int n = 1 << s;
    int dw = w64 ? 64 : 32;
    logic [63:0] v = '0;
    if (we || er) return '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = w64 ? m64[a + k] : m32[a + k];
    if (!u && v[8*n-1]) for (int b = 8 * n; b < dw; b++) v[b] = 1'b1;
    return v;
  endfunction
  function automatic void model_store(bit w64, logic [31:0] a, logic [1:0] s, logic [63:0] wd);
    for (int k = 0; k < (1 << s); k++)
      if (w64) m64[a + k] = wd[8*k +: 8];
      else m32[a + k] = wd[8*k +: 8];
  endfunction
  // one request, then wait (bounded) for its response; lat counts negedges from drive to response
  task automatic go(input bit w64, input bit we, input logic [31:0] a, input logic [1:0] s, input bit u,
                    input logic [63:0] wd, output logic [63:0] rd, output logic er,
                    output logic [63:0] xrd, output bit xer, output int lat);
    @(negedge clk);
    xer = is_err(w64 ? 64 : 32, a, s);
    xrd = model_load(w64, a, s, u, we, xer);
    if (we && !xer) model_store(w64, a, s, wd);
    if (w64) begin v64 = 1; we64 = we; a64 = a; s64 = s; u64 = u; wd64 = wd; end
    else begin v32 = 1; we32 = we; a32 = a; s32 = s; u32 = u; wd32 = wd[31:0]; end
    @(negedge clk);
    v32 = 0; v64 = 0; lat = 1;
    while (lat < 6 && !(w64 ? rv64 : rv32)) begin
      @(negedge clk);
      lat++;
    end
    rd = w64 ? rd64 : {32'h0, rd32};
    er = w64 ? er64 : er32;
  endtask
  task automatic test_reset();
    int cnt;
    logic [63:0] rd, xrd; logic er; bit xer; int lat;
    rst = 1;
    repeat (2) @(negedge clk);
    vecs++; if ({rdy32, rv32, er32, id32} !== 4'b0 || rd32 !== 32'h0) begin
      errs++; $display("FAIL reset_values got rdy=%b v=%b err=%b done=%b rdata=%h want all 0", rdy32, rv32, er32, id32, rd32); end
    rst = 0; cnt = 0;
    while (!rdy32 && cnt < 1000) begin cnt++; @(negedge clk); end
    vecs++; if (cnt != 256) begin errs++; $display("FAIL init_cycles got %0d want 256", cnt); end
    vecs++; if (id32 !== 1'b1) begin errs++; $display("FAIL init_done got %b want 1", id32); end
    vecs++; if (rdy64 !== 1'b1 || id64 !== 1'b1) begin errs++; $display("FAIL init64 got rdy=%b done=%b want 1 1", rdy64, id64); end
    model_clear();
    go(0, 0, 32'h3FC, 2'd2, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h0 || er !== 1'b0) begin errs++; $display("FAIL load_3fc got %h err=%b want 0 err=0", rd, er); end
    vecs++; if (lat != 2) begin errs++; $display("FAIL lat_3fc got %0d want 2", lat); end
  endtask
  task automatic test_unaligned();
    logic [63:0] rd, xrd; logic er; bit xer; int lat;
    go(0, 1, 32'h3, 2'd2, 0, 64'hDEADBEEF, rd, er, xrd, xer, lat);
    vecs++; if (lat != 2 || er !== 1'b0) begin errs++; $display("FAIL store_w3 got lat=%0d err=%b want 2 0", lat, er); end
    go(0, 0, 32'h3, 2'd2, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'hDEADBEEF || lat != 2) begin errs++; $display("FAIL load_w3 got %h lat=%0d want deadbeef lat=2", rd, lat); end
    go(0, 0, 32'h6, 2'd0, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'hFFFFFFDE) begin errs++; $display("FAIL load_b6s got %h want ffffffde", rd); end
    go(0, 0, 32'h6, 2'd0, 1, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h000000DE) begin errs++; $display("FAIL load_b6u got %h want 000000de", rd); end
    go(1, 1, 32'h3, 2'd2, 0, 64'hDEADBEEF, rd, er, xrd, xer, lat);
    go(1, 0, 32'h3, 2'd2, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'hFFFFFFFFDEADBEEF) begin errs++; $display("FAIL load64_w3s got %h want ffffffffdeadbeef", rd); end
  endtask
  task automatic test_half();
    logic [63:0] rd, xrd; logic er; bit xer; int lat;
    go(0, 1, 32'h10, 2'd2, 0, 64'h11223344, rd, er, xrd, xer, lat);
    go(0, 1, 32'h11, 2'd1, 0, 64'hFFFFAABB, rd, er, xrd, xer, lat);
    go(0, 0, 32'h10, 2'd2, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h11AABB44) begin errs++; $display("FAIL half_merge got %h want 11aabb44", rd); end
  endtask
  task automatic test_errors();
    logic [63:0] rd, xrd; logic er; bit xer; int lat;
    go(0, 0, 32'h8, 2'd3, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (er !== 1'b1 || rd !== 64'h0) begin errs++; $display("FAIL dword32 got err=%b %h want err=1 0", er, rd); end
    go(0, 1, 32'h3FE, 2'd1, 0, 64'h5A5A, rd, er, xrd, xer, lat);
    vecs++; if (er !== 1'b0) begin errs++; $display("FAIL half_3fe got err=%b want 0", er); end
    go(0, 1, 32'h3FE, 2'd2, 0, 64'hCAFEF00D, rd, er, xrd, xer, lat);
    vecs++; if (er !== 1'b1 || lat != 2) begin errs++; $display("FAIL word_3fe got err=%b lat=%0d want 1 2", er, lat); end
    go(0, 0, 32'h3FE, 2'd1, 1, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h5A5A || er !== 1'b0) begin errs++; $display("FAIL reload_3fe got %h err=%b want 5a5a 0", rd, er); end
    go(0, 0, 32'h400, 2'd0, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (er !== 1'b1) begin errs++; $display("FAIL byte_400 got err=%b want 1", er); end
    go(1, 1, 32'h8000_0010, 2'd0, 0, 64'h77, rd, er, xrd, xer, lat);
    vecs++; if (er !== 1'b1) begin errs++; $display("FAIL hibit64 got err=%b want 1", er); end
    go(1, 0, 32'h10, 2'd0, 1, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== xrd) begin errs++; $display("FAIL hibit64_alias got %h want %h", rd, xrd); end
  endtask
  task automatic test_random(input bit w64, input int cnt);
    logic [63:0] rd, xrd, msk; logic er; bit xer; int lat;
    logic [31:0] a; logic [1:0] s;
    msk = w64 ? '1 : 64'hFFFF_FFFF;
    for (int i = 0; i < cnt; i++) begin
      a = ($urandom_range(0, 1) ? 32'd0 : 32'd960) + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      s = 2'($urandom_range(0, 3));
      go(w64, 1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), {$urandom, $urandom} & msk, rd, er, xrd, xer, lat);
      vecs++; if (rd !== xrd || er !== xer || lat != 2) begin
        errs++; $display("FAIL rand%0d_%0d a=%h s=%0d got %h err=%b lat=%0d want %h err=%b lat=2",
                         w64 ? 64 : 32, i, a, s, rd, er, lat, xrd, xer); end
    end
  endtask
  task automatic test_back_to_back();
    logic [63:0] xq[$];
    bit eq[$];
    int sq[$];
    int got = 0, t;
    logic [63:0] x, wd;
    bit e, we, u;
    logic [31:0] a, last_a = 0;
    logic [1:0] s;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (rv64) begin
        if (sq.size() == 0) begin
          vecs++; errs++; $display("FAIL b2b_extra got rsp at cycle %0d want none", c);
        end else begin
          t = sq.pop_front(); x = xq.pop_front(); e = eq.pop_front();
          vecs++; if (rd64 !== x || er64 !== e || c - t != 2) begin
            errs++; $display("FAIL b2b_%0d got %h err=%b lat=%0d want %h err=%b lat=2", got, rd64, er64, c - t, x, e); end
          got++;
        end
      end
      if (c < 8) begin
        we = (c % 2) == 0;
        u = 1'($urandom_range(0, 1));
        wd = {$urandom, $urandom};
        a = we ? 32'($urandom_range(0, 1015)) : last_a;
        s = 2'($urandom_range(0, 3));
        if (c < 2) begin a = 32'h5; s = 2'd3; u = 0; end
        last_a = a;
        e = is_err(64, a, s);
        xq.push_back(model_load(1, a, s, u, we, e));
        eq.push_back(e);
        sq.push_back(c);
        if (we && !e) model_store(1, a, s, wd);
        v64 = 1; we64 = we; a64 = a; s64 = s; u64 = u; wd64 = wd;
      end else v64 = 0;
    end
    vecs++; if (got != 8) begin errs++; $display("FAIL b2b_count got %0d want 8", got); end
  endtask
  task automatic test_reset_mid_clear();
    int cnt = 0, seen = 0;
    logic [63:0] rd, xrd; logic er; bit xer; int lat;
    @(negedge clk); v32 = 1; we32 = 0; a32 = 32'h10; s32 = 2'd2; u32 = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    repeat (100) begin if (rv32) seen++; @(negedge clk); end
    rst = 1;
    @(negedge clk); if (rv32) seen++;
    rst = 0;
    while (!rdy32 && cnt < 1000) begin if (rv32) seen++; cnt++; @(negedge clk); end
    v32 = 0;
    if (rv32) seen++;
    vecs++; if (cnt != 256) begin errs++; $display("FAIL reinit_cycles got %0d want 256", cnt); end
    vecs++; if (seen != 0) begin errs++; $display("FAIL reinit_rsp got %0d responses want 0", seen); end
    model_clear();
    go(0, 0, 32'h10, 2'd2, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h0 || er !== 1'b0) begin errs++; $display("FAIL cleared_10 got %h err=%b want 0 0", rd, er); end
    go(1, 0, 32'h5, 2'd3, 0, 64'h0, rd, er, xrd, xer, lat);
    vecs++; if (rd !== 64'h0) begin errs++; $display("FAIL cleared64_5 got %h want 0", rd); end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_unaligned();
    test_half();
    test_errors();
    test_random(0, 60);
    test_random(1, 60);
    test_back_to_back();
    test_reset_mid_clear();
    test_random(0, 20);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
